// File: rtl/pkt_framer.sv
// pkt_framer
//   Parses a byte stream from an upstream FIFO into packets and forwards the
//   payload on a valid/ready byte interface.  Stream format: a header byte
//   ([7:6] destination port, [5:0] payload length L), then L payload bytes.
//   Zero-length headers are discarded and counted.
//
// Ports
//   clk, rst         clock, asynchronous active-low reset
//   en               allows new header reads (a packet in progress always completes)
//   fifo_empty       upstream FIFO empty flag
//   fifo_dout        upstream read data, valid one cycle after fifo_rd_en
//   fifo_rd_en       upstream pop request
//   out_valid/ready  output handshake
//   out_data         payload byte
//   out_sop/out_eop  first / last payload byte of a packet
//   out_port         destination port of the packet
//   pkt_cnt          packets completed on the output (wraps)
//   drop_cnt         zero-length headers discarded (wraps)
module pkt_framer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_dout,
  output logic             fifo_rd_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic [1:0]       out_port,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    R_HDR,
    R_HWAIT,
    R_PAY
  } rd_state_t;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [1:0] port;
    logic [7:0] data;
  } beat_t;

  rd_state_t  state;
  logic [5:0] rem;
  logic       first;
  logic [1:0] cur_port;

  // Tags of the payload read issued last cycle; its data is on fifo_dout now.
  logic       infl_v;
  logic       infl_sop;
  logic       infl_eop;
  logic [1:0] infl_port;

  // Two-entry output buffer, buf0 is the head.
  beat_t      buf0;
  beat_t      buf1;
  logic [1:0] cnt;

  logic       pop;
  logic       hdr_rd;
  logic       pay_rd;
  logic [2:0] level;
  beat_t      in_beat;

  always_comb begin
    pop     = (cnt != 2'd0) && out_ready;
    level   = {1'b0, cnt} + {2'b00, infl_v} - {2'b00, pop};
    hdr_rd  = (state == R_HDR) && en && !fifo_empty;
    pay_rd  = (state == R_PAY) && !fifo_empty && (level < 3'd2);
    in_beat = '{sop: infl_sop, eop: infl_eop, port: infl_port, data: fifo_dout};
    // Left combinational so the pop never lags fifo_empty; gated so it is
    // held low for the whole time reset is asserted.
    fifo_rd_en = rst && (hdr_rd || pay_rd);
  end

  assign out_valid = (cnt != 2'd0);
  assign out_data  = buf0.data;
  assign out_sop   = buf0.sop;
  assign out_eop   = buf0.eop;
  assign out_port  = buf0.port;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= R_HDR;
      rem       <= '0;
      first     <= 1'b0;
      cur_port  <= '0;
      infl_v    <= 1'b0;
      infl_sop  <= 1'b0;
      infl_eop  <= 1'b0;
      infl_port <= '0;
      buf0      <= '0;
      buf1      <= '0;
      cnt       <= '0;
      pkt_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      case (state)
        R_HDR: begin
          if (hdr_rd) state <= R_HWAIT;
        end
        R_HWAIT: begin
          cur_port <= fifo_dout[7:6];
          rem      <= fifo_dout[5:0];
          first    <= 1'b1;
          if (fifo_dout[5:0] == 6'd0) begin
            drop_cnt <= drop_cnt + 1'b1;
            state    <= R_HDR;
          end else begin
            state <= R_PAY;
          end
        end
        R_PAY: begin
          if (pay_rd) begin
            rem   <= rem - 6'd1;
            first <= 1'b0;
            if (rem == 6'd1) state <= R_HDR;
          end
        end
        default: state <= R_HDR;
      endcase

      infl_v <= pay_rd;
      if (pay_rd) begin
        infl_sop  <= first;
        infl_eop  <= (rem == 6'd1);
        infl_port <= cur_port;
      end

      // Read permission guarantees a push never finds both entries occupied
      // unless the head is popped in the same cycle.
      case ({pop, infl_v})
        2'b11: begin
          if (cnt == 2'd2) begin
            buf0 <= buf1;
            buf1 <= in_beat;
          end else begin
            buf0 <= in_beat;
          end
        end
        2'b10: begin
          buf0 <= buf1;
          cnt  <= cnt - 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd0) buf0 <= in_beat;
          else             buf1 <= in_beat;
          cnt <= cnt + 2'd1;
        end
        default: ;
      endcase

      if (pop && buf0.eop) pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pkt_framer.sv
// tb_pkt_framer
//   Directed bench for pkt_framer: a table of single-packet vectors plus
//   hand-written sequences for throughput, backpressure, reset and enable.
module tb_pkt_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        fifo_rd_en;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic [1:0]  out_port;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;

  pkt_framer #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_port   (out_port),
    .pkt_cnt    (pkt_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: data appears one cycle after the pop request.
  logic [7:0]  mem [0:1023];
  int unsigned wp = 0;
  int unsigned rp = 0;
  logic        flush;
  assign fifo_empty = (rp == wp);

  always @(posedge clk) begin
    if (flush) rp <= wp;
    else if (fifo_rd_en) begin
      fifo_dout <= mem[rp[9:0]];
      rp        <= rp + 1;
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records every accepted byte and watches hold / pop rules.
  int          cap_w   [0:1023];
  int unsigned cap_cyc [0:1023];
  int          cap_n   = 0;
  int          hold_err = 0;
  int          bad_rd  = 0;
  logic        stall_prev = 1'b0;
  logic [11:0] held;

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      cap_w[cap_n]   = int'({out_sop, out_eop, out_port, out_data});
      cap_cyc[cap_n] = cyc;
      cap_n          = cap_n + 1;
    end
    if (stall_prev && !(out_valid && ({out_sop, out_eop, out_port, out_data} == held)))
      hold_err = hold_err + 1;
    stall_prev = rst && out_valid && !out_ready;
    held       = {out_sop, out_eop, out_port, out_data};
    if (fifo_rd_en && fifo_empty) bad_rd = bad_rd + 1;
  end

  int checks   = 0;
  int failures = 0;
  int exp_w [0:1023];
  int exp_n    = 0;
  int cmp_from = 0;

  typedef struct {
    logic [7:0] hdr;
    logic [7:0] seed;
    logic [1:0] port;
    int         len;
    int         exp_pkt;
    int         exp_drop;
  } vec_t;

  vec_t vec [0:4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks   = checks + 1;
    failures = failures + 1;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp[9:0]] = b;
    wp = wp + 1;
  endtask

  task automatic exp_add(input logic sop, input logic eop, input logic [1:0] port,
                         input logic [7:0] data);
    exp_w[exp_n] = int'({sop, eop, port, data});
    exp_n = exp_n + 1;
  endtask

  task automatic load_pkt(input logic [7:0] hdr, input logic [7:0] seed, input logic track);
    int len;
    len = int'(hdr[5:0]);
    push(hdr);
    for (int i = 0; i < len; i++) begin
      push(seed + 8'(i));
      if (track) exp_add(i == 0, i == len - 1, hdr[7:6], seed + 8'(i));
    end
  endtask

  task automatic drain(input string name, input int budget, input logic need_empty);
    int b;
    b = 0;
    while (!(cap_n >= exp_n && (!need_empty || rp == wp)) && b < budget) begin
      step();
      b++;
    end
    if (b >= budget) timeout(name);
    repeat (3) step();
  endtask

  task automatic check_stream(input string name);
    chk({name, "_len"}, cap_n, exp_n);
    for (int i = cmp_from; i < exp_n; i++) chk(name, cap_w[i], exp_w[i]);
    cmp_from = exp_n;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_rd_en"},  int'(fifo_rd_en), 0);
    chk({name, "_valid"},  int'(out_valid), 0);
    chk({name, "_sop"},    int'(out_sop), 0);
    chk({name, "_eop"},    int'(out_eop), 0);
    chk({name, "_data"},   int'(out_data), 0);
    chk({name, "_port"},   int'(out_port), 0);
    chk({name, "_pkt"},    int'(pkt_cnt), 0);
    chk({name, "_drop"},   int'(drop_cnt), 0);
  endtask

  initial begin
    int base;
    int b;
    int occ;
    int max_occ;
    int rd_cnt;
    int unsigned rp0;

    //          hdr    seed   port len pkt drop
    vec[0] = '{8'h43, 8'hA1, 2'd1, 3, 1, 0};
    vec[1] = '{8'h80, 8'h00, 2'd2, 0, 1, 1};
    vec[2] = '{8'h01, 8'h55, 2'd0, 1, 2, 1};
    vec[3] = '{8'hC5, 8'h10, 2'd3, 5, 3, 1};
    vec[4] = '{8'h82, 8'hF0, 2'd2, 2, 4, 1};

    rst = 1'b0; en = 1'b1; out_ready = 1'b1; flush = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b1;
    step();

    // Single-packet vectors, out_ready held high.
    for (int v = 0; v < 5; v++) begin
      push(vec[v].hdr);
      for (int i = 0; i < vec[v].len; i++) begin
        push(vec[v].seed + 8'(i));
        exp_add(i == 0, i == vec[v].len - 1, vec[v].port, vec[v].seed + 8'(i));
      end
      drain("vec_drain", 200, 1'b1);
      check_stream("vec_stream");
      chk("vec_pkt_cnt",  int'(pkt_cnt),  vec[v].exp_pkt);
      chk("vec_drop_cnt", int'(drop_cnt), vec[v].exp_drop);
    end

    // Back-to-back packets: payload bytes of a packet on consecutive cycles.
    base = exp_n;
    load_pkt(8'h44, 8'h20, 1'b1);
    load_pkt(8'h83, 8'h30, 1'b1);
    load_pkt(8'hC2, 8'h40, 1'b1);
    drain("b2b_drain", 200, 1'b1);
    check_stream("b2b_stream");
    chk("b2b_pkt_cnt", int'(pkt_cnt), 7);
    chk("b2b_span0", int'(cap_cyc[base + 3] - cap_cyc[base]),     3);
    chk("b2b_span1", int'(cap_cyc[base + 6] - cap_cyc[base + 4]), 2);
    chk("b2b_span2", int'(cap_cyc[base + 8] - cap_cyc[base + 7]), 1);

    // 63-byte packet with a 10-cycle output stall mid-packet.
    base = exp_n;
    rp0  = rp;
    push(8'h3F);
    for (int i = 0; i < 63; i++) begin
      push(8'(i * 3 + 7));
      exp_add(i == 0, i == 62, 2'd0, 8'(i * 3 + 7));
    end
    b = 0;
    while (cap_n - base < 20 && b < 200) begin step(); b++; end
    if (b >= 200) timeout("bp_wait");
    out_ready = 1'b0;
    max_occ = 0;
    rd_cnt  = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      occ = int'(rp - rp0) - 1 - (cap_n - base);
      if (occ > max_occ) max_occ = occ;
      if (k >= 3 && fifo_rd_en) rd_cnt++;
    end
    chk("bp_max_occ",       max_occ, 2);
    chk("bp_rd_while_full", rd_cnt, 0);
    chk("bp_valid",         int'(out_valid), 1);
    out_ready = 1'b1;
    drain("bp_drain", 300, 1'b1);
    check_stream("bp_stream");
    chk("bp_pkt_cnt", int'(pkt_cnt), 8);

    // Reset during payload byte 5 of a 10-byte packet.
    base = exp_n;
    load_pkt(8'h0A, 8'h60, 1'b1);
    b = 0;
    while (cap_n - base < 5 && b < 200) begin step(); b++; end
    if (b >= 200) timeout("rst_wait");
    rst = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_reset_outputs("rst_mid");
    for (int i = 0; i < 5; i++) chk("rst_partial", cap_w[base + i], exp_w[base + i]);
    step();
    rst = 1'b1;
    exp_n    = cap_n;
    cmp_from = cap_n;
    load_pkt(8'h42, 8'h71, 1'b1);
    drain("rst_drain", 200, 1'b1);
    check_stream("rst_stream");
    chk("rst_pkt_cnt",  int'(pkt_cnt), 1);
    chk("rst_drop_cnt", int'(drop_cnt), 0);

    // en dropped while the payload is being read.
    rp0 = rp;
    load_pkt(8'h46, 8'h90, 1'b1);
    b = 0;
    while (rp - rp0 < 2 && b < 100) begin step(); b++; end
    if (b >= 100) timeout("en_wait");
    en = 1'b0;
    load_pkt(8'h41, 8'hEE, 1'b0);
    drain("en_drain", 200, 1'b0);
    rd_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (fifo_rd_en) rd_cnt++;
    end
    check_stream("en_stream");
    chk("en_reads",      int'(rp - rp0), 7);
    chk("en_rd_after",   rd_cnt, 0);
    chk("en_fifo_empty", int'(fifo_empty), 0);
    chk("en_pkt_cnt",    int'(pkt_cnt), 2);

    chk("hold_stable",   hold_err, 0);
    chk("rd_when_empty", bad_rd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pkt_framer.md
PKT_FRAMER -- requirements
Module: pkt_framer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the packet and drop counters.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port en  input  1  allows new header reads when high.
REQ-005 SHALL have port fifo_empty  input  1  upstream byte FIFO empty flag.
REQ-006 SHALL have port fifo_dout  input  8  upstream FIFO read data.
REQ-007 SHALL have port fifo_rd_en  output  1  upstream FIFO pop request.
REQ-008 SHALL have port out_valid  output  1  output byte valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts byte.
REQ-010 SHALL have port out_data  output  8  payload byte.
REQ-011 SHALL have port out_sop  output  1  first payload byte of packet.
REQ-012 SHALL have port out_eop  output  1  last payload byte of packet.
REQ-013 SHALL have port out_port  output  2  destination port of current packet.
REQ-014 SHALL have port pkt_cnt  output  CNT_W  packets completed on output.
REQ-015 SHALL have port drop_cnt  output  CNT_W  zero-length headers discarded.

Function
REQ-016 SHALL treat fifo_dout as valid exactly one cycle after fifo_rd_en is high, with fifo_rd_en only asserted while fifo_empty is low.
REQ-017 SHALL parse the FIFO byte stream as packets: header byte [7:6]=destination port, [5:0]=payload length L (0..63), followed by L payload bytes.
REQ-018 SHALL run a read-side FSM: R_HDR (issue header read when en && !fifo_empty) -> R_HWAIT (header returning) -> R_PAY if L>0, else R_HDR.
REQ-019 SHALL, in R_PAY, issue one payload read per cycle when permitted, decrement remaining count, and move to R_HDR in the cycle the L-th payload read issues.
REQ-020 SHALL, on L=0, increment drop_cnt, emit nothing, and return to R_HDR.
REQ-021 SHALL hold payload in a 2-entry output buffer; a payload read is permitted only when buffered + in-flight bytes, minus a same-cycle output pop, is below 2.
REQ-022 SHALL tag each payload read at issue time with sop (first byte), eop (L-th byte) and port; tags travel with the byte. For L=1 both sop and eop SHALL be set.
REQ-023 SHALL sustain one payload byte per cycle when fifo_empty low and out_ready high.
REQ-024 SHALL keep out_data/out_sop/out_eop/out_port stable while out_valid && !out_ready.
REQ-025 SHALL preserve byte order.
REQ-026 SHALL increment pkt_cnt on each out_valid && out_ready && out_eop; counters wrap modulo 2^CNT_W.
REQ-027 SHALL, when en goes low, finish the packet in progress and issue no further header reads.
REQ-028 SHALL, when fifo_empty rises mid-packet, stall reads and resume at the next non-empty cycle without loss.

Reset
REQ-029 SHALL, while rst low, drive fifo_rd_en, out_valid, out_sop, out_eop, out_data, out_port, pkt_cnt, drop_cnt to 0, empty the buffer, and enter R_HDR.
REQ-030 SHALL abandon any partial packet on reset; no eop is emitted for it.

Verification
REQ-031 Bench SHALL cover: FIFO holds 0x43,0xA1,0xA2,0xA3, out_ready=1 -> bytes A1(sop),A2,A3(eop) with out_port=1, pkt_cnt=1.
REQ-032 Bench SHALL cover: header 0x80 then 0x01,0x55 -> drop_cnt=1; one byte 0x55 with sop=eop=1, out_port=0.
REQ-033 Bench SHALL cover: 63-byte packet with out_ready held 0 for 10 cycles mid-packet -> at most 2 bytes buffered, fifo_rd_en low while full, data held, all 63 bytes delivered in order.
REQ-034 Bench SHALL cover: back-to-back packets, out_ready=1, FIFO never empty -> one payload byte per cycle within each packet, pkt_cnt matches packets sent.
REQ-035 Bench SHALL cover: rst low during payload byte 5 of 10 -> all outputs 0 next cycle; after release next FIFO byte parsed as header.
REQ-036 Bench SHALL cover: en low while in R_PAY -> current packet completes, fifo_rd_en stays low afterwards despite non-empty FIFO.
